// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
// The INIT state exists only when RAM_ACCESS_CTRL_CLEAR_EN is defined.
package ram_access_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    // Encoding of the ram_rw direction strobe
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RESP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RESP
    } state_t;
`endif

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake plus RAM-side port bundle of the RAM access controller.
// slave = controller side, master = requester / RAM environment side.
interface ram_access_ctrl_if
    import ram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ram_en, ram_rw, ram_addr, ram_din, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_rw, ram_addr, ram_din, busy
    );

endinterface

// File: rtl/ram_access_ctrl.sv
// RAM access controller: each request gets a settle cycle then a single-cycle enable strobe.
// Define RAM_ACCESS_CTRL_CLEAR_EN to zero the whole array after every reset before serving requests.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    ram_access_ctrl_if.slave bus
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_req_we;
    logic              r_ram_en;
    logic              r_ram_rw;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_clr_strobe;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
            r_state      <= ST_INIT;
            r_clr_addr   <= '0;
            r_clr_strobe <= 1'b0;
`else
            r_state      <= ST_IDLE;
`endif
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_req_we    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_rw    <= RW_READ;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // the enable is a pulse: only the states below that strobe raise it
            r_ram_en <= 1'b0;
            case (r_state)
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
                ST_INIT: begin
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    if (!r_clr_strobe) begin
                        r_ram_addr   <= r_clr_addr;
                        r_ram_din    <= '0;
                        r_ram_rw     <= RW_WRITE;
                        r_clr_strobe <= 1'b1;
                    end else begin
                        r_ram_en     <= 1'b1;
                        r_clr_strobe <= 1'b0;
                        r_clr_addr   <= r_clr_addr + ADDR_W'(1);
                        if (r_clr_addr == CLR_LAST) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_IDLE: begin
                    r_ram_rw    <= RW_READ;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    // address, data and direction go out now so SETUP is the settle cycle
                    if (r_req_ready && bus.req_valid) begin
                        r_req_we    <= bus.req_we;
                        r_ram_addr  <= bus.req_addr;
                        r_ram_din   <= bus.req_wdata;
                        r_ram_rw    <= bus.req_we ? RW_WRITE : RW_READ;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_ram_en <= 1'b1;
                    r_state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    r_ram_rw <= RW_READ;
                    if (r_req_we) begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_rsp_rdata <= bus.ram_dout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_rw    = r_ram_rw;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a driver pushes expected strobes/responses on accept,
// a negedge monitor pops and compares them against an array-level memory model.
module tb_ram_access_ctrl;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    localparam int unsigned INIT_CYC = 512;
`else
    localparam int unsigned INIT_CYC = 0;
`endif

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } ram_op_t;

    typedef struct {
        logic [7:0]  data;
        int unsigned acc;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_access_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Attached RAM: combinational read port, write on an enabled write strobe
    logic [7:0] mem      [256];
    logic [7:0] load_img [256];
    logic       load_now = 1'b0;

    assign bus.ram_dout = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < 256; i++) mem[i] <= load_img[i];
        end else if (bus.ram_en && bus.ram_rw == 1'b0) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [256];
    ram_op_t     exp_ram[$];
    rsp_exp_t    exp_rsp[$];
    int unsigned acc_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: request-ready timing, RAM strobes and responses
    int unsigned ready_at   = 0;
    int unsigned clr_next   = 0;
    logic        prev_en    = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_rr    = 1'b0;
    logic [7:0]  prev_rdata = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            exp_ram.delete();
            exp_rsp.delete();
            ready_at   = cyc + 2 + INIT_CYC;
            clr_next   = 0;
            prev_en    = 1'b0;
            prev_valid = 1'b0;
            prev_rr    = 1'b0;
        end else begin
            check("req_ready", 32'(bus.req_ready), 32'(cyc >= ready_at));
            check("busy", 32'(bus.busy), 32'(cyc < ready_at));
            if (cyc >= ready_at) begin
                check("idle_ram_en", 32'(bus.ram_en), 0);
                check("idle_ram_rw", 32'(bus.ram_rw), 1);
            end
            if (bus.ram_en) begin
                ram_op_t op;
                check("ram_en_single_pulse", 32'(prev_en), 0);
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
                if (cyc < ready_at) begin
                    check("clr_addr", 32'(bus.ram_addr), clr_next);
                    check("clr_din", 32'(bus.ram_din), 0);
                    check("clr_rw", 32'(bus.ram_rw), 0);
                    clr_next++;
                end else
`endif
                begin
                    check("strobe_expected", 32'(exp_ram.size() != 0), 1);
                    if (exp_ram.size() != 0) begin
                        op = exp_ram.pop_front();
                        check("strobe_addr", 32'(bus.ram_addr), 32'(op.addr));
                        check("strobe_rw", 32'(bus.ram_rw), 32'(op.rw));
                        if (op.rw == 1'b0) check("strobe_din", 32'(bus.ram_din), 32'(op.data));
                    end
                end
            end
            if (prev_valid && !prev_rr) check("rsp_valid_hold", 32'(bus.rsp_valid), 1);
            if (bus.rsp_valid) begin
                check("rsp_expected", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    if (!prev_valid) begin
                        check("rsp_latency", cyc - exp_rsp[0].acc, 3);
                        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rsp[0].data));
                    end else begin
                        check("rsp_rdata_stable", 32'(bus.rsp_rdata), 32'(prev_rdata));
                    end
                    if (bus.rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        ready_at = cyc + 1;
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                ready_at = bus.req_we ? cyc + 3 : 32'hFFFF_FFFF;
            end
            prev_en    = bus.ram_en;
            prev_valid = bus.rsp_valid;
            prev_rr    = bus.rsp_ready;
            prev_rdata = bus.rsp_rdata;
        end
    end

    // One clock of request drive; called just after a rising edge, returns just after the next one
    task automatic drive_cycle(input logic v, input logic we, input logic [7:0] a,
                               input logic [7:0] d, output logic acc);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        acc = v && bus.req_ready && !rst;
        if (acc) begin
            exp_ram.push_back('{rw: !we, addr: a, data: d});
            if (we) ref_mem[a] = d;
            else exp_rsp.push_back('{data: ref_mem[a], acc: cyc});
            acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        logic        acc = 1'b0;
        int unsigned n   = 0;
        while (!acc && n < 40) begin
            drive_cycle(1'b1, we, a, d, acc);
            n++;
        end
        check("issue_accept", 32'(acc), 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        bus.req_valid = 1'b0;
        while (!(bus.req_ready && exp_rsp.size() == 0 && exp_ram.size() == 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", 32'(n < budget), 1);
    endtask

    task automatic load_ram(input logic nonzero);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (nonzero) v = v | 8'h01;
            load_img[i] = v;
            ref_mem[i]  = v;
        end
        load_now = 1'b1;
        @(posedge clk);
        #1;
        load_now = 1'b0;
    endtask

    task automatic after_reset();
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        wait_idle(700);
        check("clr_strobe_count", clr_next, 256);
`else
        @(posedge clk);
        #1;
        check("post_reset_req_ready", 32'(bus.req_ready), 1);
        check("post_reset_busy", 32'(bus.busy), 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic       we_sel;
        logic [7:0] a;
        logic [7:0] held;
        int unsigned n;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        load_ram(INIT_CYC != 0);
        repeat (2) @(posedge clk);
        #1;

        // Values held while in reset
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_ram_en", 32'(bus.ram_en), 0);
        check("rst_ram_rw", 32'(bus.ram_rw), 1);
        check("rst_ram_addr", 32'(bus.ram_addr), 0);
        check("rst_ram_din", 32'(bus.ram_din), 0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        after_reset();

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        bus.rsp_ready = 1'b1;
        issue(1'b0, 8'h80, 8'h00);
        wait_idle(20);
`endif

        // Write 0x5A to 0x03 then read it back
        bus.rsp_ready = 1'b1;
        issue(1'b1, 8'h03, 8'h5A);
        issue(1'b0, 8'h03, 8'h00);
        wait_idle(20);
        check("mem_03_written", 32'(mem[3]), 32'h5A);

        // Read 0xFF with the consumer stalled for 5 cycles
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'hFF, 8'h00);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_rsp_seen", 32'(bus.rsp_valid), 1);
        held = bus.rsp_rdata;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'(i), 8'(i + 1), 8'hC3, acc);
        check("stall_rsp_valid", 32'(bus.rsp_valid), 1);
        check("stall_rsp_rdata", 32'(bus.rsp_rdata), 32'(held));
        check("stall_req_ready", 32'(bus.req_ready), 0);
        bus.rsp_ready = 1'b1;
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, acc);
        check("after_hs_req_ready", 32'(bus.req_ready), 1);
        check("after_hs_rsp_valid", 32'(bus.rsp_valid), 0);
        wait_idle(20);

        // Abort a read with reset while its strobe is on the RAM port
        issue(1'b0, 8'h10, 8'h00);
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, acc);
        check("abort_in_strobe", 32'(bus.ram_en), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        check("abort_ram_en", 32'(bus.ram_en), 0);
        check("abort_ram_rw", 32'(bus.ram_rw), 1);
        @(posedge clk);
        #1;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        wait_idle(700);
`endif
        repeat (10) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, acc);

        // Randomized mixed traffic with random back-pressure
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)     a = 8'h00;
            else if (r == 1) a = 8'hFF;
            else if (r < 6) a = 8'($urandom_range(0, 15));
            else            a = 8'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            drive_cycle($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), a, 8'($urandom), acc);
        end
        bus.rsp_ready = 1'b1;
        wait_idle(40);

        // Continuous writes: one accept every 3 cycles
        acc_log.delete();
        n = 0;
        while (acc_log.size() < 12 && n < 100) begin
            we_sel = 1'b1;
            drive_cycle(1'b1, we_sel, 8'($urandom), (acc_log.size() % 2 == 0) ? 8'hAA : 8'h55, acc);
            n++;
        end
        check("burst_accept_count", acc_log.size(), 12);
        for (int i = 1; i < acc_log.size(); i++) begin
            check("burst_accept_gap", acc_log[i] - acc_log[i-1], 3);
        end
        wait_idle(20);

        // Read back a sweep to confirm the array contents match the model
        for (int i = 0; i < 16; i++) issue(1'b0, 8'(i), 8'h00);
        wait_idle(40);
        check("drain_rsp_queue", exp_rsp.size(), 0);
        check("drain_ram_queue", exp_ram.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
